// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
// Latency: none (definitions only).
// Backpressure: not applicable.
//
// Contents: funct3 operation encodings, controller state encoding, ALU opcodes.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M mul/div controller that borrows the shared ALU for its add/sub steps.
// Latency: start -> done in 34 cycles (32 iterations + FIX + DONE); divide-by-zero/overflow in 2.
// Backpressure: start is only accepted in IDLE; the execute stage stalls while busy=1, no queueing.
//
// Ports: clk/rst (sync, active-high); start/op/opA/opB request; busy/done/result status;
// alu_srcA/alu_srcB/alu_control drive the shared ALU, alu_result returns its sum/difference.
// Build option: define MULDIV_SIGNED_EN for signed MULH/MULHSU/DIV/REM; otherwise they act unsigned.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] alu_srcA,
  output logic [DATA_WIDTH-1:0] alu_srcB,
  output logic [2:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] alu_result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  state_e          state, state_nxt;
  op_e             op_q;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    a_mag, b_mag;    // operand magnitudes captured at start
  logic [W-1:0]    acc_hi, acc_lo;  // mul: product; div: remainder / dividend->quotient

  // Operand sign handling at capture time.
  logic            sa, sb, ovf;
  logic [W-1:0]    a_abs, b_abs;
  logic            div0, special;

`ifdef MULDIV_SIGNED_EN
  logic            pneg, qneg, rneg;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (op)
      OP_MULH:        begin sa = opA[W-1]; sb = opB[W-1]; end
      OP_MULHSU:      begin sa = opA[W-1]; end
      OP_DIV, OP_REM: begin sa = opA[W-1]; sb = opB[W-1]; end
      default:        ;
    endcase
  end
  assign ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                 (opA == {1'b1, {(W-1){1'b0}}}) && (opB == {W{1'b1}});
  assign a_abs = sa ? -opA : opA;
  assign b_abs = sb ? -opB : opB;
`else
  assign sa    = 1'b0;
  assign sb    = 1'b0;
  assign ovf   = 1'b0;
  assign a_abs = opA;
  assign b_abs = opB;
`endif

  assign div0    = op[2] && (opB == '0);
  assign special = div0 || ovf;

  // Datapath step terms.
  logic            is_div;
  logic [W-1:0]    r_sh;
  logic            qbit, carry;

  assign is_div = op_q[2];
  assign r_sh   = {acc_hi[W-2:0], acc_lo[W-1]};
  // rem[msb] set means the shifted remainder is really W+1 bits and always >= divisor.
  assign qbit   = acc_hi[W-1] | (r_sh >= b_mag);
  assign carry  = (alu_result < acc_hi);

  // Sign fix-up and result selection.
  logic [2*W-1:0]  prod, prod_f;
  logic [W-1:0]    quo_f, rem_f, fix_val;

  assign prod = {acc_hi, acc_lo};
`ifdef MULDIV_SIGNED_EN
  assign prod_f = pneg ? -prod : prod;
  assign quo_f  = qneg ? -acc_lo : acc_lo;
  assign rem_f  = rneg ? -acc_hi : acc_hi;
`else
  assign prod_f = prod;
  assign quo_f  = acc_lo;
  assign rem_f  = acc_hi;
`endif

  always_comb begin
    fix_val = '0;
    case (op_q)
      OP_MUL:                       fix_val = prod_f[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_f[2*W-1:W];
      OP_DIV, OP_DIVU:              fix_val = quo_f;
      default:                      fix_val = rem_f;
    endcase
  end

  // Next-state and ALU drive.
  always_comb begin
    state_nxt   = state;
    alu_srcA    = '0;
    alu_srcB    = '0;
    alu_control = ALU_ADD;
    case (state)
      IDLE: if (start) state_nxt = special ? FIX : RUN;
      RUN: begin
        if (is_div) begin
          alu_srcA    = r_sh;
          alu_srcB    = b_mag;
          alu_control = ALU_SUB;
        end else begin
          alu_srcA    = acc_hi;
          alu_srcB    = b_mag[cnt] ? a_mag : '0;
          alu_control = ALU_ADD;
        end
        if (cnt == CW'(W-1)) state_nxt = FIX;
      end
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_MUL;
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
`ifdef MULDIV_SIGNED_EN
      pneg   <= 1'b0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          op_q  <= op_e'(op);
          a_mag <= a_abs;
          b_mag <= b_abs;
          cnt   <= '0;
`ifdef MULDIV_SIGNED_EN
          pneg  <= sa ^ sb;
          qneg  <= (sa ^ sb) & ~special;  // special-case quotients are already final
          rneg  <= sa;
`endif
          if (div0) begin
            acc_hi <= a_abs;
            acc_lo <= '1;
          end else if (ovf) begin
            acc_hi <= '0;
            acc_lo <= {1'b1, {(W-1){1'b0}}};
          end else if (op[2]) begin
            // Dividend starts in acc_lo and is shifted out as quotient bits shift in.
            acc_hi <= '0;
            acc_lo <= a_abs;
          end else begin
            acc_hi <= '0;
            acc_lo <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= qbit ? alu_result : r_sh;
            acc_lo <= {acc_lo[W-2:0], qbit};
          end else begin
            acc_hi <= {carry, alu_result[W-1:1]};
            acc_lo <= {alu_result[0], acc_lo[W-1:1]};
          end
        end
        FIX:     result <= fix_val;
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and random ops against an arithmetic model.
// Latency: checks done at exactly start+34 (or start+2 for special cases).
// Backpressure: includes a start pulse during busy, which must be ignored.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opA, opB;
  logic        busy, done;
  logic [31:0] result;
  logic [31:0] alu_srcA, alu_srcB;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU.
  assign alu_result = (alu_control == 3'b001) ? (alu_srcA - alu_srcB) : (alu_srcA + alu_srcB);

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .result(result),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_control(alu_control),
    .alu_result(alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Without signed support the signed ops collapse onto their unsigned twins.
  function automatic logic [2:0] norm_op(input logic [2:0] o);
`ifdef MULDIV_SIGNED_EN
    return o;
`else
    case (o)
      3'b001, 3'b010: return 3'b011;
      3'b100:         return 3'b101;
      3'b110:         return 3'b111;
      default:        return o;
    endcase
`endif
  endfunction

  function automatic bit is_ovf(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [2:0] n;
    n = norm_op(o);
    return ((n == 3'b100) || (n == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return (o[2] && (b == 32'd0)) || is_ovf(o, a, b);
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] xa, xb, sp;
    logic        [63:0] up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (norm_op(o))
      3'b000: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'b001: begin xa = {{32{a[31]}}, a}; xb = {{32{b[31]}}, b}; sp = xa * xb; return sp[63:32]; end
      3'b010: begin xa = {{32{a[31]}}, a}; xb = {32'd0, b}; sp = xa * xb; return sp[63:32]; end
      3'b011: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (is_ovf(o, a, b)) return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (is_ovf(o, a, b)) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // One complete operation; poke=1 pulses start again while busy.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] exp;
    int          lat;
    bit          early;
    exp   = ref_model(o, a, b);
    lat   = is_special(o, a, b) ? 1 : 33;
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); opA = $urandom; opB = $urandom;  // must not disturb captured values
    chk("busy_after_start", busy, 1);
    if (lat > 1) chk("alu_ctl_run", alu_control, o[2] ? 3'b001 : 3'b000);
    early = 1'b0;
    for (int i = 1; i < lat; i++) begin
      if (poke && i == 4) begin
        start = 1'b1; op = 3'b000; opA = 32'd3; opB = 32'd3;
      end
      @(negedge clk);
      start = 1'b0;
      if (done) early = 1'b1;
    end
    chk("no_early_done", early, 0);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("result", result, exp);
    @(negedge clk);
    chk("done_cleared", done, 0);
    chk("idle_after", busy, 0);
    chk("result_held", result, exp);
    chk("alu_idle_srcA", alu_srcA, 0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit          seen;

    rst = 1'b1; start = 1'b0; op = 3'd0; opA = 32'd0; opB = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_ctl", alu_control, 0);
    rst = 1'b0;

    run_op(3'b000, 32'd7, 32'd6, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 1'b0);
    run_op(3'b111, 32'd100, 32'd7, 1'b0);
    run_op(3'b101, 32'd5, 32'd0, 1'b0);
    run_op(3'b111, 32'd5, 32'd0, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b001, 32'hFFFF_FFF9, 32'd3, 1'b0);
    run_op(3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b000, 32'd1234, 32'd5678, 1'b1);

    // Reset mid-run abandons the operation without a done pulse.
    @(negedge clk);
    op = 3'b000; opA = 32'd9; opB = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run_op(3'b101, 32'd1000, 32'd33, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(ro, ra, rb, n[2]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
